collision_score_unit: RTL

Parametrised successor to the combinational collision/score logic of the Pong datapath. Evaluates ball position against walls and both paddles once per ball-update strobe and emits registered one-cycle event pulses. Owns both score counters, counting exactly once per missed ball, and a match FSM that detects the winner. Sits between the ball mover (consumes events) and the score display / top-level control.

---
 rtl/collision_score_unit.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/collision_score_unit.sv
// -----------------------------------------------------------------------------
// collision_score_unit
//
// Purpose:
//   Evaluates the ball position against the top/bottom walls and both paddles
//   once per ball-update strobe, emits registered one-cycle event pulses, owns
//   both score counters and runs the match FSM (IDLE/RALLY/POINT/OVER) that
//   detects the winner. Every output comes straight from a register, so there
//   is no combinational path from any input to any output.
//
// Ports:
//   clk         in   1        system clock
//   rst         in   1        synchronous active-high reset
//   ball_step   in   1        one-cycle strobe, bx/by hold a new ball position
//   bx, by      in   COORD_W  ball column / row
//   p1y, p2y    in   COORD_W  left / right paddle top row
//   new_game    in   1        clear scores and start a rally
//   paddle_hit  out  2        pulse: 01 left hit, 11 right hit, 00 none
//   wall_hit    out  1        pulse: ball on row 0 or FIELD_MAX
//   point_p1    out  1        pulse: player 1 scored
//   point_p2    out  1        pulse: player 2 scored
//   sc1, sc2    out  SCORE_W  player scores (saturate at WIN_SCORE)
//   serve_dir   out  1        side that conceded the last point (0 left)
//   game_over   out  1        high while the match is decided
//   winner      out  1        valid with game_over: 0 player 1, 1 player 2
// -----------------------------------------------------------------------------
module collision_score_unit #(
  parameter int COORD_W   = 6,
  parameter int FIELD_MAX = 63,
  parameter int PADDLE_H  = 6,
  parameter int P1_X      = 2,
  parameter int P2_X      = 61,
  parameter int SCORE_W   = 3,
  parameter int WIN_SCORE = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ball_step,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] p1y,
  input  logic [COORD_W-1:0] p2y,
  input  logic               new_game,
  output logic [1:0]         paddle_hit,
  output logic               wall_hit,
  output logic               point_p1,
  output logic               point_p2,
  output logic [SCORE_W-1:0] sc1,
  output logic [SCORE_W-1:0] sc2,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner
);

  // Paddle range arithmetic is one bit wider than the coordinates so a paddle
  // whose top row sits near FIELD_MAX does not wrap back to row 0.
  localparam int EXT_W = COORD_W + 1;

  localparam logic [EXT_W-1:0]   PAD_SPAN = EXT_W'(PADDLE_H - 1);
  localparam logic [COORD_W-1:0] P1_COL   = COORD_W'(P1_X);
  localparam logic [COORD_W-1:0] P2_COL   = COORD_W'(P2_X);
  localparam logic [COORD_W-1:0] TOP_ROW  = '0;
  localparam logic [COORD_W-1:0] BOT_ROW  = COORD_W'(FIELD_MAX);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SC_ONE   = SCORE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RALLY = 2'd1,
    S_POINT = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t             r_state;
  logic [1:0]         r_paddle_hit;
  logic               r_wall_hit;
  logic               r_point_p1;
  logic               r_point_p2;
  logic [SCORE_W-1:0] r_sc1;
  logic [SCORE_W-1:0] r_sc2;
  logic               r_serve_dir;
  logic               r_game_over;
  logic               r_winner;

  // ---------------------------------------------------------------------------
  // Paddle range test, one instance per paddle (index 0 left, 1 right).
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] w_pad_top [2];
  logic [1:0]         w_in_range;

  assign w_pad_top[0] = p1y;
  assign w_pad_top[1] = p2y;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pad
      logic [EXT_W-1:0] w_top;
      logic [EXT_W-1:0] w_bot;
      logic [EXT_W-1:0] w_row;

      assign w_top = {1'b0, w_pad_top[gi]};
      assign w_bot = w_top + PAD_SPAN;
      assign w_row = {1'b0, by};
      assign w_in_range[gi] = (w_row >= w_top) && (w_row <= w_bot);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Event decode for the current ball position.
  // ---------------------------------------------------------------------------
  logic w_hit_left;
  logic w_hit_right;
  logic w_miss_left;
  logic w_miss_right;
  logic w_wall;
  logic w_in_play;

  assign w_hit_left   = (bx == P1_COL) && w_in_range[0];
  assign w_hit_right  = (bx == P2_COL) && w_in_range[1];
  // A ball at or beyond a paddle column that was not returned is a miss; this
  // also covers a ball mover that overshoots the paddle column.
  assign w_miss_left  = (bx <= P1_COL) && !w_hit_left;
  assign w_miss_right = (bx >= P2_COL) && !w_hit_right;
  assign w_wall       = (by == TOP_ROW) || (by == BOT_ROW);
  // Strictly between the paddles: the ball mover has re-served.
  assign w_in_play    = (bx > P1_COL) && (bx < P2_COL);

  // Scores in RALLY are always below WIN_SCORE, so the increment cannot wrap.
  logic [SCORE_W-1:0] w_sc1_inc;
  logic [SCORE_W-1:0] w_sc2_inc;

  assign w_sc1_inc = r_sc1 + SC_ONE;
  assign w_sc2_inc = r_sc2 + SC_ONE;

  // ---------------------------------------------------------------------------
  // Match FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_paddle_hit <= 2'b00;
      r_wall_hit   <= 1'b0;
      r_point_p1   <= 1'b0;
      r_point_p2   <= 1'b0;
      r_sc1        <= '0;
      r_sc2        <= '0;
      r_serve_dir  <= 1'b0;
      r_game_over  <= 1'b0;
      r_winner     <= 1'b0;
    end else begin
      // Pulses fall back to zero unless an evaluated strobe sets them.
      r_paddle_hit <= 2'b00;
      r_wall_hit   <= 1'b0;
      r_point_p1   <= 1'b0;
      r_point_p2   <= 1'b0;

      if (new_game) begin
        // serve_dir deliberately survives a new game.
        r_sc1       <= '0;
        r_sc2       <= '0;
        r_game_over <= 1'b0;
        r_winner    <= 1'b0;
        r_state     <= S_RALLY;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end

          S_RALLY: begin
            if (ball_step) begin
              r_wall_hit <= w_wall;

              if (w_hit_left) begin
                r_paddle_hit <= 2'b01;
              end else if (w_hit_right) begin
                r_paddle_hit <= 2'b11;
              end

              if (w_miss_left) begin
                r_point_p2  <= 1'b1;
                r_sc2       <= w_sc2_inc;
                r_serve_dir <= 1'b0;
                if (w_sc2_inc == WIN_VAL) begin
                  r_state     <= S_OVER;
                  r_game_over <= 1'b1;
                  r_winner    <= 1'b1;
                end else begin
                  r_state <= S_POINT;
                end
              end else if (w_miss_right) begin
                r_point_p1  <= 1'b1;
                r_sc1       <= w_sc1_inc;
                r_serve_dir <= 1'b1;
                if (w_sc1_inc == WIN_VAL) begin
                  r_state     <= S_OVER;
                  r_game_over <= 1'b1;
                  r_winner    <= 1'b0;
                end else begin
                  r_state <= S_POINT;
                end
              end
            end
          end

          S_POINT: begin
            // The re-serve strobe only ends the lock-out; it is not scored.
            if (ball_step && w_in_play) begin
              r_state <= S_RALLY;
            end
          end

          S_OVER: begin
            r_state <= S_OVER;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign paddle_hit = r_paddle_hit;
  assign wall_hit   = r_wall_hit;
  assign point_p1   = r_point_p1;
  assign point_p2   = r_point_p2;
  assign sc1        = r_sc1;
  assign sc2        = r_sc2;
  assign serve_dir  = r_serve_dir;
  assign game_over  = r_game_over;
  assign winner     = r_winner;

endmodule
